// File: rtl/btn_debounce_tick.sv
// Per-button debouncer sampled on rising edges of a slow tick; produces clean levels,
// single-clock press/release pulses and optional auto-repeat pulses while held.
module btn_debounce_tick #(
  parameter int NUM_BTN      = 4,
  parameter int STABLE_TICKS = 100,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 3000,
  parameter int REPEAT_RATE  = 500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_in,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int CNT_W   = (STABLE_TICKS > 2) ? $clog2(STABLE_TICKS) : 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_TICKS - 1);
  localparam logic [REP_W-1:0] REP_FIRST  = REP_W'(REPEAT_DELAY);
  // Reload point so that later repeats land every REPEAT_RATE strobes without wrapping.
  localparam logic [REP_W-1:0] REP_RELOAD =
    REP_W'((REPEAT_DELAY >= REPEAT_RATE) ? (REPEAT_DELAY - REPEAT_RATE) : 0);

  typedef enum logic [1:0] {ST_UP, ST_UP_CHK, ST_DOWN, ST_DOWN_CHK} state_t;

  logic [NUM_BTN-1:0] sync1_reg;
  logic [NUM_BTN-1:0] sync2_reg;
  logic               tick_d_reg;
  logic               stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      tick_d_reg <= 1'b0;
    end else begin
      sync1_reg  <= btn_raw;
      sync2_reg  <= sync1_reg;
      tick_d_reg <= tick_in;
    end
  end

  assign stb = tick_in & ~tick_d_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      state_t           state_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic [REP_W-1:0] rep_reg;
      logic [REP_W-1:0] rep_inc;
      logic             level_reg;
      logic             press_reg;
      logic             release_reg;
      logic             repeat_reg;
      logic             bsync;

      assign bsync   = sync2_reg[gi];
      assign rep_inc = rep_reg + REP_W'(1);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg   <= ST_UP;
          cnt_reg     <= '0;
          rep_reg     <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          repeat_reg  <= 1'b0;
        end else begin
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          repeat_reg  <= 1'b0;
          if (stb) begin
            case (state_reg)
              ST_UP: begin
                if (bsync) begin
                  state_reg <= ST_UP_CHK;
                  cnt_reg   <= CNT_W'(1);
                end
              end
              ST_UP_CHK: begin
                if (!bsync) begin
                  state_reg <= ST_UP;
                  cnt_reg   <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= ST_DOWN;
                  cnt_reg   <= '0;
                  rep_reg   <= '0;
                  level_reg <= 1'b1;
                  press_reg <= 1'b1;
                end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
                end
              end
              ST_DOWN: begin
                if (!bsync) begin
                  state_reg <= ST_DOWN_CHK;
                  cnt_reg   <= CNT_W'(1);
                end else if (REPEAT_EN != 0) begin
                  if (rep_inc == REP_FIRST) begin
                    repeat_reg <= 1'b1;
                    rep_reg    <= REP_RELOAD;
                  end else begin
                    rep_reg <= rep_inc;
                  end
                end
              end
              ST_DOWN_CHK: begin
                if (bsync) begin
                  state_reg <= ST_DOWN;
                  cnt_reg   <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                  state_reg   <= ST_UP;
                  cnt_reg     <= '0;
                  level_reg   <= 1'b0;
                  release_reg <= 1'b1;
                end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
                end
              end
              default: begin
                state_reg <= ST_UP;
                cnt_reg   <= '0;
              end
            endcase
          end
        end
      end

      assign btn_level[gi]   = level_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
      assign btn_repeat[gi]  = repeat_reg;
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce_tick.sv
// Randomized + directed bench for btn_debounce_tick; a strobe-level reference model queues
// expected pulse events which a monitor matches against the DUT outputs.
module tb_btn_debounce_tick;

  localparam int NB = 2;
  localparam int ST = 4;
  localparam int RD = 6;
  localparam int RR = 3;
  localparam int TICK_HALF = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_in = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  btn_debounce_tick #(
    .NUM_BTN(NB), .STABLE_TICKS(ST), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  initial forever #5 clk = ~clk;

  // 0 = free-running 20-clk square wave, 1 = stuck low, 2 = stuck high
  int tick_mode = 0;
  int tick_cnt  = 0;
  always @(negedge clk) begin
    if (tick_mode == 0) begin
      tick_cnt = tick_cnt + 1;
      if (tick_cnt == TICK_HALF) begin
        tick_cnt = 0;
        tick_in  = ~tick_in;
      end
    end else if (tick_mode == 1) begin
      tick_in = 1'b0;
    end else begin
      tick_in = 1'b1;
    end
  end

  typedef struct {
    int unsigned   cyc;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic [NB-1:0] rpt;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: works on strobes, counting consecutive samples that disagree with the
  // accepted level and strobes held steadily down for the repeat schedule.
  int unsigned   cyc = 0;
  logic [NB-1:0] lvl_m = '0;
  logic [NB-1:0] s1_m = '0, s2_m = '0;
  logic          tick_prev_m = 1'b0;
  int            run_m[NB];
  int            hold_m[NB];

  always @(posedge clk) begin
    logic [NB-1:0] bs, prs, rel, rpt;
    logic          stb;
    ev_t           e;
    cyc = cyc + 1;
    if (rst) begin
      lvl_m = '0; s1_m = '0; s2_m = '0; tick_prev_m = 1'b0;
      for (int b = 0; b < NB; b++) begin run_m[b] = 0; hold_m[b] = 0; end
      exp_q.delete();
    end else begin
      bs = s2_m; s2_m = s1_m; s1_m = btn_raw;
      stb = tick_in && !tick_prev_m;
      tick_prev_m = tick_in;
      if (stb) begin
        prs = '0; rel = '0; rpt = '0;
        for (int b = 0; b < NB; b++) begin
          if (bs[b] != lvl_m[b]) begin
            run_m[b] = run_m[b] + 1;
            if (run_m[b] == ST) begin
              lvl_m[b] = bs[b];
              if (bs[b]) prs[b] = 1'b1; else rel[b] = 1'b1;
              run_m[b]  = 0;
              hold_m[b] = 0;
            end
          end else begin
            if (lvl_m[b] && run_m[b] == 0) begin
              hold_m[b] = hold_m[b] + 1;
              if (hold_m[b] == RD || (hold_m[b] > RD && (hold_m[b] - RD) % RR == 0))
                rpt[b] = 1'b1;
            end
            run_m[b] = 0;
          end
        end
        if ((prs | rel | rpt) != '0) begin
          e.cyc = cyc; e.lvl = lvl_m; e.prs = prs; e.rel = rel; e.rpt = rpt;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: pops an expected event whenever the DUT shows any pulse
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (rst) begin
      checks = checks + 1;
      if ({btn_level, btn_press, btn_release, btn_repeat} != '0) begin
        errors = errors + 1;
        $display("FAIL reset_outputs cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b expected all 0",
                 cyc, btn_level, btn_press, btn_release, btn_repeat);
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL missing_pulse cyc=%0d got nothing expected prs=%b rel=%b rpt=%b",
                 e.cyc, e.prs, e.rel, e.rpt);
      end
      if ((btn_press | btn_release | btn_repeat) != '0) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL spurious_pulse cyc=%0d got prs=%b rel=%b rpt=%b expected none",
                   cyc, btn_press, btn_release, btn_repeat);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.prs != btn_press || e.rel != btn_release ||
              e.rpt != btn_repeat || e.lvl != btn_level) begin
            errors = errors + 1;
            $display("FAIL pulse_event cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b expected cyc=%0d lvl=%b prs=%b rel=%b rpt=%b",
                     cyc, btn_level, btn_press, btn_release, btn_repeat,
                     e.cyc, e.lvl, e.prs, e.rel, e.rpt);
          end else begin
            $display("event cyc=%0d lvl=%b prs=%b rel=%b rpt=%b", cyc,
                     btn_level, btn_press, btn_release, btn_repeat);
          end
        end
      end
      checks = checks + 1;
      if (btn_level != lvl_m) begin
        errors = errors + 1;
        $display("FAIL level cyc=%0d got %b expected %b", cyc, btn_level, lvl_m);
      end
    end
  end

  task automatic strobes(input int n);
    repeat (n * 2 * TICK_HALF) @(negedge clk);
  endtask

  initial begin
    // reset with both buttons held and tick running; held buttons must debounce after release
    rst = 1'b1; btn_raw = 2'b11;
    repeat (60) @(negedge clk);
    rst = 1'b0;
    strobes(8);
    btn_raw = 2'b00; strobes(6);

    // clean press with repeats, then release
    btn_raw = 2'b01; strobes(16);
    btn_raw = 2'b00; strobes(6);

    // bounce: 3 high, 1 low, five times
    repeat (5) begin
      btn_raw = 2'b01; strobes(3);
      btn_raw = 2'b00; strobes(1);
    end
    strobes(5);

    // single-strobe release glitch while held
    btn_raw = 2'b01; strobes(12);
    btn_raw = 2'b00; strobes(1);
    btn_raw = 2'b01; strobes(10);
    btn_raw = 2'b00; strobes(6);

    // simultaneous press
    btn_raw = 2'b11; strobes(5);
    btn_raw = 2'b00; strobes(6);

    // tick stuck low, then stuck high, while buttons toggle
    tick_mode = 1;
    repeat (500) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) btn_raw = NB'($urandom);
    end
    tick_mode = 2;
    btn_raw = 2'b11;
    repeat (200) @(negedge clk);
    btn_raw = 2'b00;
    tick_mode = 0;
    strobes(8);

    // reset while btn0 is mid-debounce
    btn_raw = 2'b01; strobes(2);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    btn_raw = 2'b00;
    rst = 1'b0;
    strobes(5);

    // random hold lengths at arbitrary clock offsets
    repeat (120) begin
      btn_raw = NB'($urandom);
      repeat ($urandom_range(1, 160)) @(negedge clk);
    end
    btn_raw = 2'b00;
    strobes(8);

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL queue_drain got %0d pending events expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
